// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter : round-robin two-master arbiter for one synchronous memory port
// Revision    : 1.0
// ----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          Clock_i,
  input  logic          Resetn_i,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic          we0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          gnt0_o,
  output logic          gnt1_o,
  output logic          ack0_o,
  output logic          ack1_o,
  output logic [DW-1:0] rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_owner_q;
  logic            ack0_q, ack1_q, mem_en_q, mem_we_q, busy_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic            win_d;
  logic            accept_d;

  // last_owner doubles as the owner of the in-flight transaction, since it
  // only changes on an accept and no accept can happen during ISSUE.
  always_comb begin
    state_d  = state_q;
    win_d    = last_owner_q;
    accept_d = 1'b0;
    gnt0_o   = 1'b0;
    gnt1_o   = 1'b0;

    if (req0_i && req1_i) begin
      win_d = ~last_owner_q;
    end else begin
      win_d = req1_i;
    end

    accept_d = Resetn_i && (state_q != ISSUE) && (req0_i || req1_i);
    gnt0_o   = accept_d && !win_d;
    gnt1_o   = accept_d && win_d;

    case (state_q)
      IDLE:    state_d = accept_d ? ISSUE : IDLE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = accept_d ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock_i) begin
    if (!Resetn_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      mem_en_q <= accept_d;
      mem_we_q <= accept_d && (win_d ? we1_i : we0_i);
      ack0_q   <= (state_q == ISSUE) && !last_owner_q;
      ack1_q   <= (state_q == ISSUE) && last_owner_q;
      busy_q   <= (state_d != IDLE);
      if (accept_d) begin
        last_owner_q <= win_d;
        mem_addr_q   <= win_d ? addr1_i : addr0_i;
        mem_wdata_q  <= win_d ? wdata1_i : wdata0_i;
      end
    end
  end

  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;
  assign rdata_o     = mem_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter : table-driven vectors plus directed multi-cycle sequences
// for the two-master memory arbiter, with a small behavioural memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, ack0, ack1, mem_en, mem_we, busy;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .Clock_i    (clk),
    .Resetn_i   (rstn),
    .req0_i     (req0),
    .req1_i     (req1),
    .we0_i      (we0),
    .we1_i      (we1),
    .addr0_i    (addr0),
    .addr1_i    (addr1),
    .wdata0_i   (wdata0),
    .wdata1_i   (wdata1),
    .gnt0_o     (gnt0),
    .gnt1_o     (gnt1),
    .ack0_o     (ack0),
    .ack1_o     (ack1),
    .rdata_o    (rdata),
    .mem_en_o   (mem_en),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .busy_o     (busy)
  );

  // One-cycle-latency synchronous memory
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  typedef struct {
    logic        rstn, r0, r1, w0, w1;
    logic [15:0] a0, a1, d0, d1;
    logic        chkr, g0, g1, k0, k1, en, we;
    logic [15:0] ma, md;
    logic        bsy, chkd;
    logic [15:0] rd;
  } vec_t;

  vec_t tv [11];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input string tag, input logic k0, input logic k1,
                          input logic en, input logic we, input logic bsy);
    chk1({tag, " ack0"}, ack0, k0);
    chk1({tag, " ack1"}, ack1, k1);
    chk1({tag, " mem_en"}, mem_en, en);
    chk1({tag, " mem_we"}, mem_we, we);
    chk1({tag, " busy"}, busy, bsy);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hBEEF;

    //        rstn  r0    r1    w0    w1    a0       a1       d0       d1
    //        chkr  g0    g1    k0    k1    en    we    ma       md       bsy   chkd  rd
    tv[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0020, 16'h0000, 16'h1234,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tv[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0020, 16'h0000, 16'h1234,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0020, 16'h0000, 16'h1234,
               1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0020, 16'h0000, 16'h1234,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0020, 16'h0000, 16'h1234,
               1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'hBEEF};
    tv[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0020, 16'h0000, 16'h1234,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0020, 16'h0000, 16'h1234,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b0, 16'h0000};
    tv[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0020, 16'h0000, 16'h1234,
               1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h1234, 1'b1, 1'b0, 16'h0000};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0020, 16'h0000, 16'h1234,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0000};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0020, 16'h0000, 16'h1234,
               1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b1, 16'h1234};
    tv[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0020, 16'h0000, 16'h1234,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000};

    // Reset, single read, single write, read-back of the written word
    for (int i = 0; i < 11; i++) begin
      rstn = tv[i].rstn; req0 = tv[i].r0; req1 = tv[i].r1;
      we0 = tv[i].w0; we1 = tv[i].w1;
      addr0 = tv[i].a0; addr1 = tv[i].a1; wdata0 = tv[i].d0; wdata1 = tv[i].d1;
      #1;
      chk1($sformatf("v%0d gnt0", i), gnt0, tv[i].g0);
      chk1($sformatf("v%0d gnt1", i), gnt1, tv[i].g1);
      if (tv[i].chkr) begin
        chk_regs($sformatf("v%0d", i), tv[i].k0, tv[i].k1, tv[i].en, tv[i].we, tv[i].bsy);
        chk16($sformatf("v%0d mem_addr", i), mem_addr, tv[i].ma);
        chk16($sformatf("v%0d mem_wdata", i), mem_wdata, tv[i].md);
      end
      if (tv[i].chkd) chk16($sformatf("v%0d rdata", i), rdata, tv[i].rd);
      @(negedge clk);
    end

    // Contention from reset: both requesters held, grants alternate 0,1,0,1
    rstn = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0040; addr1 = 16'h0041;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk1("rst gnt0", gnt0, 1'b0);
      chk1("rst gnt1", gnt1, 1'b0);
      @(negedge clk);
    end
    rstn = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k == 8) begin req0 = 1'b0; req1 = 1'b0; end
      #1;
      chk1($sformatf("cont%0d gnt0", k), gnt0, (k % 4 == 0) && (k < 8));
      chk1($sformatf("cont%0d gnt1", k), gnt1, (k % 4 == 2));
      chk_regs($sformatf("cont%0d", k), (k % 4 == 2), (k % 4 == 0) && (k >= 4),
               (k % 2 == 1), 1'b0, (k >= 1));
      if (k % 2 == 1)
        chk16($sformatf("cont%0d mem_addr", k), mem_addr, (k % 4 == 1) ? 16'h0040 : 16'h0041);
      @(negedge clk);
    end

    // Back-to-back from master 0 alone: addresses 1, 2, 3
    req0 = 1'b1; addr0 = 16'h0001;
    for (int c = 0; c <= 7; c++) begin
      if (c == 1) addr0 = 16'h0002;
      if (c == 3) addr0 = 16'h0003;
      if (c == 5) req0 = 1'b0;
      #1;
      chk1($sformatf("b2b%0d gnt0", c), gnt0, (c % 2 == 0) && (c <= 4));
      chk1($sformatf("b2b%0d gnt1", c), gnt1, 1'b0);
      chk_regs($sformatf("b2b%0d", c), (c % 2 == 0) && (c >= 2) && (c <= 6), 1'b0,
               (c % 2 == 1) && (c <= 5), 1'b0, (c >= 1) && (c <= 6));
      if (c == 1) chk16("b2b mem_addr 1", mem_addr, 16'h0001);
      if (c == 3) chk16("b2b mem_addr 2", mem_addr, 16'h0002);
      if (c == 5) chk16("b2b mem_addr 3", mem_addr, 16'h0003);
      @(negedge clk);
    end

    // Reset during ISSUE of a write aborts it
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0030; wdata1 = 16'h5555;
    #1;
    chk1("abort gnt1", gnt1, 1'b1);
    @(negedge clk);
    req1 = 1'b0; rstn = 1'b0;
    #1;
    chk1("abort issue mem_en", mem_en, 1'b1);
    chk1("abort issue mem_we", mem_we, 1'b1);
    @(negedge clk);
    rstn = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 16'h0050;
    #1;
    chk_regs("abort after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("abort after gnt0", gnt0, 1'b1);
    chk1("abort after gnt1", gnt1, 1'b0);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    #1;
    chk1("abort next mem_en", mem_en, 1'b1);
    chk16("abort next mem_addr", mem_addr, 16'h0050);
    @(negedge clk);
    #1;
    chk1("abort next ack0", ack0, 1'b1);
    chk1("abort next ack1", ack1, 1'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
